// File: rtl/mem_access.sv
// MEM pipeline stage with a multi-cycle data memory; optional alignment check via MEM_ALIGN_CHK_EN.
// Non-memory ops complete in 1 cycle, memory ops in WAIT_CYC cycles with stall held meanwhile.
module mem_access #(
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [1:0]  wb_ctl_in,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] add_result,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2,
    input  logic        zero,
    input  logic [4:0]  dst_in,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        out_valid,
    output logic [1:0]  wb_ctl_out,
    output logic [31:0] read_data,
    output logic [31:0] alu_out,
    output logic [4:0]  dst_out,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        stall_q;
    logic        out_valid_q;
    logic [1:0]  wb_ctl_q;
    logic [31:0] read_data_q;
    logic [31:0] alu_out_q;
    logic [4:0]  dst_q;

    logic        req_rd_q;
    logic        req_wr_q;
    logic [31:0] req_alu_q;
    logic [31:0] req_data_q;
    logic [1:0]  req_wb_q;
    logic [4:0]  req_dst_q;

    logic [31:0] mem_q [DEPTH];

    logic          mem_op;
    logic          mis_in;
    logic [AW-1:0] idx_in;
    logic [AW-1:0] idx_req;
    logic          fast_done;
    logic          busy_done;
    logic          mem_we;
    logic [AW-1:0] mem_widx;
    logic [31:0]   mem_wdat;
    logic [31:0]   rd_fast;
    logic [31:0]   rd_busy;

    assign pcsrc         = in_valid & branch & zero;
    assign branch_target = add_result;

    assign mem_op  = memread | memwrite;
    assign idx_in  = alu_result[AW+1:2];
    assign idx_req = req_alu_q[AW+1:2];

`ifdef MEM_ALIGN_CHK_EN
    logic misalign_q;
    assign mis_in   = mem_op & (alu_result[1:0] != 2'b00);
    assign misalign = misalign_q;
`else
    assign mis_in   = 1'b0;
    assign misalign = 1'b0;
`endif

    assign fast_done = (state_q == IDLE) && in_valid && (!mem_op || (WAIT_CYC == 1) || mis_in);
    assign busy_done = (state_q == BUSY) && (cnt_q == 3'd1);

    // Writes land only on the completion edge, so a reset mid-access leaves memory untouched.
    assign mem_we   = rst_n && ((fast_done && memwrite && !mis_in) || (busy_done && req_wr_q));
    assign mem_widx = busy_done ? idx_req : idx_in;
    assign mem_wdat = busy_done ? req_data_q : rdata2;

    assign rd_fast = (memread && !memwrite && !mis_in) ? mem_q[idx_in] : 32'd0;
    assign rd_busy = (req_rd_q && !req_wr_q) ? mem_q[idx_req] : 32'd0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            stall_q     <= 1'b0;
            out_valid_q <= 1'b0;
            wb_ctl_q    <= 2'd0;
            read_data_q <= 32'd0;
            alu_out_q   <= 32'd0;
            dst_q       <= 5'd0;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
            req_alu_q   <= 32'd0;
            req_data_q  <= 32'd0;
            req_wb_q    <= 2'd0;
            req_dst_q   <= 5'd0;
`ifdef MEM_ALIGN_CHK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fast_done) begin
                        out_valid_q <= 1'b1;
                        wb_ctl_q    <= wb_ctl_in;
                        alu_out_q   <= alu_result;
                        dst_q       <= dst_in;
                        read_data_q <= rd_fast;
`ifdef MEM_ALIGN_CHK_EN
                        misalign_q  <= mis_in;
`endif
                    end else if (in_valid) begin
                        req_rd_q   <= memread;
                        req_wr_q   <= memwrite;
                        req_alu_q  <= alu_result;
                        req_data_q <= rdata2;
                        req_wb_q   <= wb_ctl_in;
                        req_dst_q  <= dst_in;
                        cnt_q      <= 3'(WAIT_CYC - 1);
                        stall_q    <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        out_valid_q <= 1'b1;
                        wb_ctl_q    <= req_wb_q;
                        alu_out_q   <= req_alu_q;
                        dst_q       <= req_dst_q;
                        read_data_q <= rd_busy;
`ifdef MEM_ALIGN_CHK_EN
                        misalign_q  <= 1'b0;
`endif
                        stall_q     <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall      = stall_q;
    assign out_valid  = out_valid_q;
    assign wb_ctl_out = wb_ctl_q;
    assign read_data  = read_data_q;
    assign alu_out    = alu_out_q;
    assign dst_out    = dst_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access at DEPTH=256, WAIT_CYC=2.
module tb_mem_access;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  wb_ctl_in;
    logic        branch;
    logic        memread;
    logic        memwrite;
    logic [31:0] add_result;
    logic [31:0] alu_result;
    logic [31:0] rdata2;
    logic        zero;
    logic [4:0]  dst_in;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        stall;
    logic        out_valid;
    logic [1:0]  wb_ctl_out;
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  dst_out;
    logic        misalign;

    int n_checks = 0;
    int n_err    = 0;

    mem_access #(.DEPTH(256), .WAIT_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wb_ctl_in(wb_ctl_in),
        .branch(branch), .memread(memread), .memwrite(memwrite),
        .add_result(add_result), .alu_result(alu_result), .rdata2(rdata2),
        .zero(zero), .dst_in(dst_in), .pcsrc(pcsrc), .branch_target(branch_target),
        .stall(stall), .out_valid(out_valid), .wb_ctl_out(wb_ctl_out),
        .read_data(read_data), .alu_out(alu_out), .dst_out(dst_out), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] dst);
        in_valid   = 1'b1;
        wb_ctl_in  = 2'b01;
        branch     = 1'b0;
        zero       = 1'b0;
        add_result = 32'd0;
        memread    = rd;
        memwrite   = wr;
        alu_result = addr;
        rdata2     = data;
        dst_in     = dst;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        zero     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wb_ctl_in = 2'b00; add_result = 32'd0; alu_result = 32'd0; rdata2 = 32'd0; dst_in = 5'd0;
        #3;
        check("rst_stall", stall, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_alu_out", alu_out, 32'd0);
        check("rst_dst_out", dst_out, 5'd0);
        check("rst_wb_ctl", wb_ctl_out, 2'd0);
        check("rst_misalign", misalign, 1'b0);
        tick(); tick();
        rst_n = 1'b1;

        // Non-memory ALU op
        op(1'b0, 1'b0, 32'h1234, 32'd0, 5'd5);
        tick();
        check("alu_stall", stall, 1'b0);
        check("alu_out_valid", out_valid, 1'b1);
        check("alu_alu_out", alu_out, 32'h1234);
        check("alu_dst_out", dst_out, 5'd5);
        check("alu_read_data", read_data, 32'd0);
        check("alu_wb_ctl", wb_ctl_out, 2'b01);
        idle();
        tick();
        check("alu_pulse_end", out_valid, 1'b0);
        check("alu_hold", alu_out, 32'h1234);

        // Store then back-to-back load of the same word
        op(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 5'd7);
        tick();
        check("st_stall", stall, 1'b1);
        check("st_no_valid_yet", out_valid, 1'b0);
        idle();
        tick();
        check("st_stall_drop", stall, 1'b0);
        check("st_out_valid", out_valid, 1'b1);
        check("st_read_data", read_data, 32'd0);
        op(1'b1, 1'b0, 32'h40, 32'd0, 5'd9);
        tick();
        check("ld_stall", stall, 1'b1);
        check("ld_no_valid_yet", out_valid, 1'b0);
        idle();
        tick();
        check("ld_stall_drop", stall, 1'b0);
        check("ld_out_valid", out_valid, 1'b1);
        check("ld_read_data", read_data, 32'hDEADBEEF);
        check("ld_dst_out", dst_out, 5'd9);

        // memread and memwrite together: write only, read_data 0
        op(1'b1, 1'b1, 32'h80, 32'hCAFE0001, 5'd3);
        tick(); idle(); tick();
        check("rw_out_valid", out_valid, 1'b1);
        check("rw_read_data", read_data, 32'd0);
        op(1'b1, 1'b0, 32'h80, 32'd0, 5'd4);
        tick(); idle(); tick();
        check("rw_readback", read_data, 32'hCAFE0001);

        // Address wrap modulo DEPTH words
        op(1'b0, 1'b1, 32'h400, 32'h55, 5'd1);
        tick(); idle(); tick();
        op(1'b1, 1'b0, 32'h0, 32'd0, 5'd2);
        tick(); idle(); tick();
        check("wrap_read_data", read_data, 32'h55);

        // Branch decision is combinational
        op(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        branch = 1'b1; zero = 1'b1; add_result = 32'h100;
        #1;
        check("br_pcsrc_taken", pcsrc, 1'b1);
        check("br_target", branch_target, 32'h100);
        zero = 1'b0;
        #1;
        check("br_pcsrc_zero0", pcsrc, 1'b0);
        idle();
        tick();

        // Misaligned load
        op(1'b1, 1'b0, 32'h41, 32'd0, 5'd6);
        tick();
`ifdef MEM_ALIGN_CHK_EN
        check("mis_stall", stall, 1'b0);
        check("mis_out_valid", out_valid, 1'b1);
        check("mis_flag", misalign, 1'b1);
        check("mis_read_data", read_data, 32'd0);
        idle();
        tick();
`else
        check("mis_stall", stall, 1'b1);
        idle();
        tick();
        check("mis_out_valid", out_valid, 1'b1);
        check("mis_flag", misalign, 1'b0);
        check("mis_read_data", read_data, 32'hDEADBEEF);
`endif

        // Reset in the middle of a store
        op(1'b0, 1'b1, 32'h10, 32'h11111111, 5'd8);
        tick(); idle(); tick();
        op(1'b0, 1'b1, 32'h10, 32'h22222222, 5'd8);
        tick();
        check("rb_stall", stall, 1'b1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_async_stall", stall, 1'b0);
        check("rb_async_valid", out_valid, 1'b0);
        check("rb_async_alu_out", alu_out, 32'd0);
        tick();
        check("rb_in_reset_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        check("rb_after_valid", out_valid, 1'b0);
        op(1'b1, 1'b0, 32'h10, 32'd0, 5'd10);
        tick(); idle(); tick();
        check("rb_load_valid", out_valid, 1'b1);
        check("rb_old_data", read_data, 32'h11111111);
        check("rb_load_dst", dst_out, 5'd10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data-memory size in 32-bit words (power of two, 16..1024).
REQ-002 SHALL have parameter WAIT_CYC, default 2, meaning the number of cycles a memory access occupies (1..7).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  in  1  the EX/MEM register holds a valid instruction.
REQ-006 SHALL have port wb_ctl_in  in  2  write-back control bits from EX/MEM.
REQ-007 SHALL have ports branch, memread, memwrite  in  1 each  memory-stage control bits.
REQ-008 SHALL have ports add_result, alu_result, rdata2  in  32 each  branch target, effective address/ALU result, and store data.
REQ-009 SHALL have ports zero  in  1  (ALU zero flag) and dst_in  in  5  (destination register).
REQ-010 SHALL have ports pcsrc  out  1  (take branch) and branch_target  out  32  (branch target).
REQ-011 SHALL have port stall  out  1  which holds the upstream pipeline while asserted.
REQ-012 SHALL have ports out_valid  out  1, wb_ctl_out  out  2, read_data  out  32, alu_out  out  32, dst_out  out  5  forming the MEM/WB register.
REQ-013 SHALL have port misalign  out  1  (alignment-fault flag; see Configuration).

Function
REQ-014 SHALL drive pcsrc = in_valid & branch & zero and branch_target = add_result combinationally, with no dependence on the FSM state.
REQ-015 SHALL use FSM states IDLE and BUSY.
REQ-016 IDLE, in_valid=1 with no memread/memwrite: SHALL register the inputs into MEM/WB on the next edge, set out_valid=1, set read_data=0, and stay in IDLE (latency 1).
REQ-017 IDLE, in_valid=1 with memread or memwrite: SHALL capture address, data, control and dst into request registers; WAIT_CYC=1 completes on that edge like REQ-016, otherwise SHALL go to BUSY with count=WAIT_CYC-1.
REQ-018 BUSY: SHALL decrement count each cycle; at count=1 SHALL perform the access, load MEM/WB with out_valid=1, and return to IDLE.
REQ-019 stall SHALL equal 1 in BUSY and 0 in IDLE; inputs are ignored while BUSY.
REQ-020 out_valid SHALL be a one-cycle pulse per completed instruction; MEM/WB data holds its value between pulses.
REQ-021 SHALL form the word index as alu_result[log2(DEPTH)+1:2]; upper address bits SHALL be ignored (the address wraps modulo DEPTH words).
REQ-022 SHALL commit a write only on the completion edge; a read SHALL return the memory word at completion.
REQ-023 With memread and memwrite both set, SHALL perform the write only and return read_data=0.
REQ-024 SHALL make a read to an address written by the immediately preceding instruction return the new data.
REQ-025 in_valid=0 in IDLE SHALL produce out_valid=0 and no state change.

Reset
REQ-026 rst_n=0 SHALL immediately force the state to IDLE, count=0, stall=0, out_valid=0, wb_ctl_out=0, read_data=0, alu_out=0, dst_out=0, and misalign=0.
REQ-027 Reset during BUSY SHALL discard the pending access: no memory write occurs and no out_valid is produced.
REQ-028 Memory contents SHALL be unaffected by reset.

Configuration
REQ-029 Macro MEM_ALIGN_CHK_EN defined: a memory op with alu_result[1:0]!=0 SHALL skip the access, complete in 1 cycle with read_data=0, and raise misalign=1 together with out_valid.
REQ-030 Macro MEM_ALIGN_CHK_EN undefined: alu_result[1:0] SHALL be ignored and misalign SHALL be tied to 0.

Verification
REQ-031 Bench SHALL check reset: drive rst_n=0 mid-BUSY on a store to 0x10, then read 0x10 -> the old value is returned and out_valid never pulses for the store.
REQ-032 Bench SHALL check store then load at WAIT_CYC=2: store 0xDEADBEEF to 0x40, then load 0x40 -> stall high for 1 cycle each, and read_data=0xDEADBEEF with dst_out matching.
REQ-033 Bench SHALL check a non-memory op: ALU op alu_result=0x1234, dst=5 -> no stall, and out_valid next cycle with alu_out=0x1234, dst_out=5.
REQ-034 Bench SHALL check the branch path: branch=1, zero=1, add_result=0x100 -> pcsrc=1 and branch_target=0x100 in the same cycle; with zero=0 -> pcsrc=0.
REQ-035 Bench SHALL check wrap-around: with DEPTH=256, store 0x55 to address 0x400, then load 0x0 -> read_data=0x55.
REQ-036 Bench SHALL check alignment: with MEM_ALIGN_CHK_EN defined, load 0x41 -> misalign=1, read_data=0, and no stall.
